// File: rtl/mux_16x1_tdm_scanner.sv
// Captures a 16-bit word on start and time-division-multiplexes it onto y,
// presenting each channel for HOLD cycles with its 4-bit select alongside.
module mux_16x1_tdm_scanner #(
    parameter int unsigned HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d,
    input  logic        start,
    output logic        y,
    output logic        s3,
    output logic        s2,
    output logic        s1,
    output logic        s0,
    output logic        frame,
    output logic        busy,
    output logic        done
);

    localparam int unsigned NCH = 16;
    localparam int unsigned CW  = 4;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [NCH-1:0]   shadow, shadow_nxt;
    logic [CW-1:0]    ch, ch_nxt;
    logic [CW-1:0]    hcnt, hcnt_nxt;

    logic [CW-1:0]    sel, sel_nxt;
    logic             y_nxt;
    logic             frame_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    // State, datapath and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            shadow <= '0;
            ch     <= '0;
            hcnt   <= '0;
            sel    <= '0;
            y      <= 1'b0;
            frame  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            ch     <= ch_nxt;
            hcnt   <= hcnt_nxt;
            sel    <= sel_nxt;
            y      <= y_nxt;
            frame  <= frame_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state logic; outputs are a registered view of the current state.
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        ch_nxt     = ch;
        hcnt_nxt   = hcnt;
        sel_nxt    = '0;
        y_nxt      = 1'b0;
        frame_nxt  = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                done_nxt = (state == ST_DONE);
                if (start) begin
                    shadow_nxt = d;
                    ch_nxt     = '0;
                    hcnt_nxt   = '0;
                    state_nxt  = ST_SCAN;
                end else begin
                    state_nxt  = ST_IDLE;
                end
            end
            ST_SCAN: begin
                busy_nxt  = 1'b1;
                sel_nxt   = ch;
                y_nxt     = shadow[ch];
                frame_nxt = (ch == '0);
                if (hcnt == HOLD_LAST) begin
                    hcnt_nxt = '0;
                    // Channel 15 ends the frame without wrapping ch.
                    if (ch == CH_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        ch_nxt = ch + CW'(1);
                    end
                end else begin
                    hcnt_nxt = hcnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign s3 = sel[3];
    assign s2 = sel[2];
    assign s1 = sel[1];
    assign s0 = sel[0];

endmodule
